// File: rtl/rename_pkg.sv
// Shared rename-stage types and sizes: physical register index and issue width.
package rename_pkg;
  localparam int PREGS   = 64;
  localparam int AREGS   = 32;
  localparam int DEPTH   = PREGS - AREGS;
  localparam int PREG_W  = $clog2(PREGS);
  localparam int ISSUE_W = 4;
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;

  typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/phys_free_list.sv
// Physical register free list: 4-wide pop to rename, 4-wide push from ROB retire.
// Flop-based circular buffer with wrap-bit pointers; outputs peek at the head.
module phys_free_list
  import rename_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [PREG_W-1:0] i_ret_p0,
  input  logic [PREG_W-1:0] i_ret_p1,
  input  logic [PREG_W-1:0] i_ret_p2,
  input  logic [PREG_W-1:0] i_ret_p3,
  input  logic [2:0]        i_ret_count,
  input  logic [2:0]        i_alloc_count,
  output logic [PREG_W-1:0] o_alloc_p0,
  output logic [PREG_W-1:0] o_alloc_p1,
  output logic [PREG_W-1:0] o_alloc_p2,
  output logic [PREG_W-1:0] o_alloc_p3,
  output logic              o_alloc_ok,
  output logic [PTR_W-1:0]  o_avail,
  output logic              o_overflow
);

  preg_t             mem_q [DEPTH];
  preg_t             mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic              ovf_q, ovf_d;

  preg_t             ret   [ISSUE_W];
  preg_t             rd    [ISSUE_W];
  logic [IDX_W-1:0]  wr_idx[ISSUE_W];
  logic [ISSUE_W-1:0] wr_en;
  logic [PTR_W-1:0]  pop_n;
  logic [PTR_W:0]    fill_after;
  logic              push_ok;

  assign ret[0] = i_ret_p0;
  assign ret[1] = i_ret_p1;
  assign ret[2] = i_ret_p2;
  assign ret[3] = i_ret_p3;

  assign o_avail    = tail_q - head_q;
  assign o_alloc_ok = PTR_W'(i_alloc_count) <= o_avail;
  assign pop_n      = o_alloc_ok ? PTR_W'(i_alloc_count) : '0;

  // Popped entries are credited before the push is judged, so full + pop4 + push4 fits.
  assign fill_after = {1'b0, o_avail} - {1'b0, pop_n} + (PTR_W+1)'(i_ret_count);
  assign push_ok    = fill_after <= (PTR_W+1)'(DEPTH);

  for (genvar n = 0; n < ISSUE_W; n++) begin : g_lane
    assign rd[n]     = mem_q[head_q[IDX_W-1:0] + IDX_W'(n)];
    assign wr_idx[n] = tail_q[IDX_W-1:0] + IDX_W'(n);
    assign wr_en[n]  = push_ok && (3'(n) < i_ret_count);
  end

  assign o_alloc_p0 = rd[0];
  assign o_alloc_p1 = rd[1];
  assign o_alloc_p2 = rd[2];
  assign o_alloc_p3 = rd[3];
  assign o_overflow = ovf_q;

  always_comb begin
    mem_d = mem_q;
    for (int n = 0; n < ISSUE_W; n++)
      if (wr_en[n]) mem_d[wr_idx[n]] = ret[n];
    head_d = head_q + pop_n;
    tail_d = push_ok ? tail_q + PTR_W'(i_ret_count) : tail_q;
    ovf_d  = ovf_q | ~push_ok;
  end

  // Reset hands out p(AREGS)..p(PREGS-1); the list starts full.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= preg_t'(AREGS + k);
      head_q <= '0;
      tail_q <= PTR_W'(DEPTH);
      ovf_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef FORMAL
  always_ff @(posedge i_clk)
    if (i_rst_n) assert (i_ret_count <= 3'd4 && i_alloc_count <= 3'd4);
`endif

endmodule

// File: tb/tb_phys_free_list.sv
// Directed scoreboard bench for phys_free_list: each cycle's expected peek is queued
// by the stimulus and checked by a negedge monitor.
module tb_phys_free_list;
  import rename_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       ret_p [4];
  logic [2:0]       ret_count, alloc_count;
  logic [5:0]       alloc_p [4];
  logic             alloc_ok, overflow;
  logic [5:0]       avail;

  typedef struct packed {
    logic [5:0]       avail;
    logic             ok;
    logic             ovf;
    logic [2:0]       np;
    logic [3:0][5:0]  p;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  phys_free_list dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ret_p0(ret_p[0]), .i_ret_p1(ret_p[1]), .i_ret_p2(ret_p[2]), .i_ret_p3(ret_p[3]),
    .i_ret_count(ret_count), .i_alloc_count(alloc_count),
    .o_alloc_p0(alloc_p[0]), .o_alloc_p1(alloc_p[1]),
    .o_alloc_p2(alloc_p[2]), .o_alloc_p3(alloc_p[3]),
    .o_alloc_ok(alloc_ok), .o_avail(avail), .o_overflow(overflow)
  );

  task automatic chk(input string nm, input string f, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, f, act, exp);
    end
  endtask

  // Monitor: outputs are a combinational peek, valid every cycle once stimulus is applied.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      chk(nm, "avail", int'(avail), int'(e.avail));
      chk(nm, "ok", int'(alloc_ok), int'(e.ok));
      chk(nm, "ovf", int'(overflow), int'(e.ovf));
      for (int n = 0; n < 4; n++)
        if (n < int'(e.np)) chk(nm, $sformatf("p%0d", n), int'(alloc_p[n]), int'(e.p[n]));
    end
  end

  task automatic step(input int ac, input int rc, input int r0, input int r1, input int r2,
                      input int r3, input int ea, input bit eok, input bit eovf, input int np,
                      input int e0, input int e1, input int e2, input int e3, input string nm);
    exp_t e;
    alloc_count = 3'(ac);
    ret_count   = 3'(rc);
    ret_p[0] = 6'(r0); ret_p[1] = 6'(r1); ret_p[2] = 6'(r2); ret_p[3] = 6'(r3);
    e.avail = 6'(ea); e.ok = eok; e.ovf = eovf; e.np = 3'(np);
    e.p[0] = 6'(e0); e.p[1] = 6'(e1); e.p[2] = 6'(e2); e.p[3] = 6'(e3);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; alloc_count = '0; ret_count = '0;
    for (int n = 0; n < 4; n++) ret_p[n] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset image
    step(0,0, 0,0,0,0, 32,1,0, 4, 32,33,34,35, "reset");

    // drain 32..63 four at a time
    for (int c = 0; c < 8; c++)
      step(4,0, 0,0,0,0, 32-4*c,1,0, 4, 32+4*c,33+4*c,34+4*c,35+4*c, $sformatf("drain%0d", c));
    step(1,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0, "empty_refuse");

    // retire into empty list; no same-cycle bypass
    step(1,2, 5,9,0,0, 0,0,0, 0, 0,0,0,0, "retire_nobypass");
    step(0,0, 0,0,0,0, 2,1,0, 2, 5,9,0,0, "retire_visible");
    step(3,0, 0,0,0,0, 2,0,0, 2, 5,9,0,0, "partial_refuse");
    step(2,0, 0,0,0,0, 2,1,0, 2, 5,9,0,0, "pop_two");

    // advance tail to index 30, then a 4-wide push straddles 31 -> 0
    for (int c = 0; c < 7; c++)
      step(0,4, 36+4*c,37+4*c,38+4*c,39+4*c, 4*c,1,0, (c == 0) ? 0 : 4, 36,37,38,39,
           $sformatf("fill%0d", c));
    step(4,4, 1,2,3,4, 28,1,0, 4, 36,37,38,39, "wrap_push");
    for (int c = 0; c < 6; c++)
      step(4,0, 0,0,0,0, 28-4*c,1,0, 4, 40+4*c,41+4*c,42+4*c,43+4*c, $sformatf("unwind%0d", c));
    step(4,0, 0,0,0,0, 4,1,0, 4, 1,2,3,4, "wrap_pop");

    // fill to full, then pop4+push4 at full, then an overflowing push
    for (int c = 0; c < 8; c++)
      step(0,4, 32+4*c,33+4*c,34+4*c,35+4*c, 4*c,1,0, (c == 0) ? 0 : 4, 32,33,34,35,
           $sformatf("refill%0d", c));
    step(4,4, 10,11,12,13, 32,1,0, 4, 32,33,34,35, "full_pop_push");
    step(0,1, 20,0,0,0, 32,1,0, 4, 36,37,38,39, "full_push_drop");
    step(0,0, 0,0,0,0, 32,1,1, 4, 36,37,38,39, "ovf_set");
    step(1,0, 0,0,0,0, 32,1,1, 4, 36,37,38,39, "ovf_pop");
    step(0,0, 0,0,0,0, 31,1,1, 4, 37,38,39,40, "ovf_sticky");

    // reset while traffic is applied
    rst_n = 1'b0;
    alloc_count = 3'd3; ret_count = 3'd2; ret_p[0] = 6'd7; ret_p[1] = 6'd8;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0,0, 0,0,0,0, 32,1,0, 4, 32,33,34,35, "reset_mid");
    step(2,0, 0,0,0,0, 32,1,0, 4, 32,33,34,35, "post_reset_pop");
    step(0,0, 0,0,0,0, 30,1,0, 4, 34,35,36,37, "post_reset_peek");

    @(negedge clk); #1;
    chk("end", "pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
